vpe_frame_dispatcher: RTL and testbench
=======================================

// Module: vpe_frame_dispatcher
// PURPOSE
//  Upstream feeder for the VPE array. Gathers single-tile jobs (vec1, vec2, scal, mode) arriving over a
//  valid/ready stream into a frame of PARALLEL_SIZE x PIPE_STAGE slots. Presents each completed frame as
//  VPE operand buses, held stable under valid/ready backpressure. Double-buffered (ping-pong): one
//  bank fills while the other is presented.
// PARAMETERS
//  PARALLEL_SIZE  6    outer VPE dimension (i)
//  PIPE_STAGE     7    inner VPE dimension (j)
//  TILE_SIZE      128  elements per vector tile
//  MUL_WIDTH      16   bits per element / scalar
//  SLOTS (localparam) = PARALLEL_SIZE*PIPE_STAGE = 42
// PORTS
//  clk_i       in   1                           clock
//  rst_i       in   1                           async reset, active-high
//  in_valid_i  in   1                           job valid
//  in_ready_o  out  1                           job accepted when in_valid_i & in_ready_o
//  in_vec1_i   in   TILE_SIZE*MUL_WIDTH          job vector 1
//  in_vec2_i   in   TILE_SIZE*MUL_WIDTH          job vector 2
//  in_scal_i   in   MUL_WIDTH                   job scalar
//  in_mode_i   in   1                           1: scalar op, 0: vector op
//  flush_i     in   1                           seal the partially filled frame
//  out_valid_o out  1                           frame presented
//  out_ready_i in   1                           consumer takes frame
//  operand1_o  out  [P][S][TILE][W]             per-slot vec1, to VPE operand1_i
//  operand2_o  out  [P][S][TILE][W]             per-slot vec2, to VPE operand2_i
//  operand3_o  out  [P][S][W]                   per-slot scalar, to VPE operand3_i
//  mode_o      out  [P][S]                      per-slot mode, to VPE mode
//  slot_mask_o out  [P][S]                      1 = slot holds a valid job
// BEHAVIOUR
//  - Reset (async): both banks FREE, fill/present pointers 0, write slot 0, out_valid_o=0.
//    All operand/mode/mask outputs read 0. in_ready_o=1 from the first cycle after reset deassertion.
//  - Per-bank state FREE -> FILLING (first accept) -> SEALED (full or flush) -> FREE (popped).
//  - Slot order: k-th accepted job of a frame goes to i=k/PIPE_STAGE, j=k%PIPE_STAGE; sets mask bit.
//  - in_ready_o = fill bank is FREE or FILLING (combinational from state; independent of in_valid_i).
//  - Seal on accept into slot SLOTS-1, or on flush_i while fill bank FILLING. Accept and flush in the
//    same cycle: the job is written first, then the bank is sealed (single seal). flush_i with fill
//    bank FREE, or with fill bank SEALED: ignored, no empty frame.
//  - On seal, the fill pointer toggles and the write slot returns to 0.
//  - out_valid_o = present bank SEALED. Pop on out_valid_o & out_ready_i: bank -> FREE, present
//    pointer toggles.
//  - Latency: a frame sealed at edge t shows out_valid_o=1 from t (registered state, no comb path
//    from in_* to out_*). Back-to-back: 42 accepts/frame at 1 job/cycle with out_ready_i=1, no bubbles.
//  - Pop and seal in the same cycle are both legal. A bank popped at edge t accepts writes from t.
//  - Both banks SEALED: in_ready_o=0 until a pop.
//  - Output stability: while out_valid_o & !out_ready_i, all out buses are constant.
//  - Unused slots and out_valid_o=0: operand1/2/3_o, mode_o forced 0 by mask gating. Stale bank
//    contents are never visible, and banks are not cleared on release.
//  - Reset mid-frame: all pending and sealed jobs are discarded. Next accepted job lands in slot (0,0).
//  - Protocol assumption: in_* stable while in_valid_i & !in_ready_o. Not checked in RTL; SVA in the bench.
// STRUCTURE
//  - vpe_pkg: PARALLEL_SIZE, PIPE_STAGE, TILE_SIZE, MUL_WIDTH constants;
//    tile_vec_t = logic [TILE_SIZE-1:0][MUL_WIDTH-1:0];
//    bank_state_e {BANK_FREE, BANK_FILLING, BANK_SEALED}; slot_idx_t = logic [$clog2(SLOTS)-1:0].
//  - Sub-module vpe_frame_bank (x2): slot storage plus mask, write port (we, slot_idx, job),
//    clear_mask on seal-release, full-frame read.
//  - Top: bank state FSMs, fill/present pointers, slot counter, output mux and mask gating.
// TESTING
//  1. 42 jobs back-to-back, job k has scal=k, out_ready_i=1 -> out_valid_o the cycle after the 42nd
//     accept, mask all 1, operand3_o[i][j]==7*i+j, in_ready_o never low.
//  2. 84 jobs, out_ready_i=0 -> in_ready_o=0 after the 84th accept. Raise out_ready_i for 1 cycle ->
//     frame 0 (scal 0..41) popped, frame 1 (scal 42..83) presented, in_ready_o=1 next cycle.
//  3. 5 jobs then flush_i -> mask=0b11111 (slots (0,0)..(0,4)), all other slots' operands/mode = 0.
//  4. flush_i on empty fill bank and flush_i with 5th accept same cycle -> no empty frame; single
//     5-slot frame.
//  5. Frame presented, out_ready_i=0 for 20 cycles while new jobs stream -> out buses bit-identical
//     every cycle.
//  6. Assert rst_i after 10 jobs with one sealed frame pending -> out_valid_o=0 and all outputs 0
//     immediately. Post-reset job scal=0xBEEF appears at slot (0,0) of the next frame.

Source files
------------

// File: rtl/vpe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vpe_pkg
//  Brief    : Shared constants and types for the VPE frame dispatcher slice.
//  Revision : 1.0 - initial release
// ============================================================================
package vpe_pkg;

    localparam int PARALLEL_SIZE = 6;
    localparam int PIPE_STAGE    = 7;
    localparam int TILE_SIZE     = 128;
    localparam int MUL_WIDTH     = 16;
    localparam int SLOTS         = PARALLEL_SIZE * PIPE_STAGE;
    localparam int SLOT_W        = $clog2(SLOTS);

    typedef logic [TILE_SIZE-1:0][MUL_WIDTH-1:0] tile_vec_t;
    typedef logic [SLOT_W-1:0]                   slot_idx_t;

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_SEALED  = 2'd2
    } bank_state_e;

    typedef struct packed {
        tile_vec_t            vec1;
        tile_vec_t            vec2;
        logic [MUL_WIDTH-1:0] scal;
        logic                 mode;
    } job_t;

    typedef tile_vec_t [PARALLEL_SIZE-1:0][PIPE_STAGE-1:0]              vec_frame_t;
    typedef logic [PARALLEL_SIZE-1:0][PIPE_STAGE-1:0][MUL_WIDTH-1:0]    scal_frame_t;
    typedef logic [PARALLEL_SIZE-1:0][PIPE_STAGE-1:0]                   bit_frame_t;

    // Row-major slot numbering: job k lands at (k / PIPE_STAGE, k % PIPE_STAGE)
    function automatic slot_idx_t slot_of(input int row, input int col);
        return slot_idx_t'(row * PIPE_STAGE + col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpe_frame_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : vpe_frame_dispatcher_if
//  Brief    : Job stream and frame presentation bus of the frame dispatcher.
//  Revision : 1.0 - initial release
// ============================================================================
interface vpe_frame_dispatcher_if;
    import vpe_pkg::*;

    logic                 in_valid_i;
    logic                 in_ready_o;
    tile_vec_t            in_vec1_i;
    tile_vec_t            in_vec2_i;
    logic [MUL_WIDTH-1:0] in_scal_i;
    logic                 in_mode_i;
    logic                 flush_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    vec_frame_t           operand1_o;
    vec_frame_t           operand2_o;
    scal_frame_t          operand3_o;
    bit_frame_t           mode_o;
    bit_frame_t           slot_mask_o;

    modport master (
        output in_valid_i, in_vec1_i, in_vec2_i, in_scal_i, in_mode_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, operand1_o, operand2_o, operand3_o, mode_o, slot_mask_o
    );

    modport slave (
        input  in_valid_i, in_vec1_i, in_vec2_i, in_scal_i, in_mode_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, operand1_o, operand2_o, operand3_o, mode_o, slot_mask_o
    );

endinterface
`default_nettype wire

// File: rtl/vpe_frame_bank.sv
`default_nettype none
// ============================================================================
//  Module   : vpe_frame_bank
//  Brief    : One frame of slot storage with a per-slot valid mask.
//  Revision : 1.0 - initial release
// ============================================================================
module vpe_frame_bank
    import vpe_pkg::*;
(
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic we_i,
    input  wire logic clear_mask_i,
    input  slot_idx_t slot_i,
    input  job_t      job_i,
    output vec_frame_t  vec1_o,
    output vec_frame_t  vec2_o,
    output scal_frame_t scal_o,
    output bit_frame_t  mode_o,
    output bit_frame_t  mask_o
);

    vec_frame_t  vec1_q;
    vec_frame_t  vec2_q;
    scal_frame_t scal_q;
    bit_frame_t  mode_q;
    bit_frame_t  mask_q;
    bit_frame_t  w_hit;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < PARALLEL_SIZE; i++) begin
            for (int j = 0; j < PIPE_STAGE; j++) begin
                w_hit[i][j] = we_i && (slot_i == slot_of(i, j));
            end
        end
    end

    // Payload is never cleared; the mask alone decides what is visible
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < PARALLEL_SIZE; i++) begin
            for (int j = 0; j < PIPE_STAGE; j++) begin
                if (w_hit[i][j]) begin
                    vec1_q[i][j] <= job_i.vec1;
                    vec2_q[i][j] <= job_i.vec2;
                    scal_q[i][j] <= job_i.scal;
                    mode_q[i][j] <= job_i.mode;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= (clear_mask_i ? '0 : mask_q) | w_hit;
        end
    end

    assign vec1_o = vec1_q;
    assign vec2_o = vec2_q;
    assign scal_o = scal_q;
    assign mode_o = mode_q;
    assign mask_o = mask_q;

endmodule
`default_nettype wire

// File: rtl/vpe_frame_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : vpe_frame_dispatcher
//  Brief    : Ping-pong frame builder feeding jobs to the VPE operand buses.
//  Revision : 1.0 - initial release
// ============================================================================
module vpe_frame_dispatcher
    import vpe_pkg::*;
(
    input wire logic              clk_i,
    input wire logic              rst_i,
    vpe_frame_dispatcher_if.slave bus
);

    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic        fill_ptr_q, fill_ptr_d;
    logic        pres_ptr_q, pres_ptr_d;
    slot_idx_t   wslot_q, wslot_d;

    logic        w_in_ready, w_out_valid, w_accept, w_seal, w_pop;
    logic [1:0]  w_we, w_clear;
    job_t        w_job;
    vec_frame_t  w_vec1 [2];
    vec_frame_t  w_vec2 [2];
    scal_frame_t w_scal [2];
    bit_frame_t  w_mode [2];
    bit_frame_t  w_mask [2];
    bit_frame_t  w_gate;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q[0] <= BANK_FREE;
            state_q[1] <= BANK_FREE;
            fill_ptr_q <= 1'b0;
            pres_ptr_q <= 1'b0;
            wslot_q    <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            fill_ptr_q <= fill_ptr_d;
            pres_ptr_q <= pres_ptr_d;
            wslot_q    <= wslot_d;
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (w_clear[b]) state_d[b] = BANK_FREE;
            if (w_we[b])    state_d[b] = BANK_FILLING;
            if (w_seal && (fill_ptr_q == 1'(b))) state_d[b] = BANK_SEALED;
        end
        fill_ptr_d = fill_ptr_q ^ w_seal;
        pres_ptr_d = pres_ptr_q ^ w_pop;
        if (w_seal)        wslot_d = '0;
        else if (w_accept) wslot_d = wslot_q + slot_idx_t'(1);
        else               wslot_d = wslot_q;
    end

    // A flush that coincides with an accept seals after the write, even into a FREE bank
    always_comb begin
        w_in_ready  = (state_q[fill_ptr_q] == BANK_FREE) || (state_q[fill_ptr_q] == BANK_FILLING);
        w_out_valid = (state_q[pres_ptr_q] == BANK_SEALED);
        w_accept    = bus.in_valid_i && w_in_ready;
        w_pop       = w_out_valid && bus.out_ready_i;
        w_seal      = (w_accept && (wslot_q == slot_idx_t'(SLOTS - 1)))
                   || (bus.flush_i && ((state_q[fill_ptr_q] == BANK_FILLING) || w_accept));
        for (int b = 0; b < 2; b++) begin
            w_we[b]    = w_accept && (fill_ptr_q == 1'(b));
            w_clear[b] = w_pop && (pres_ptr_q == 1'(b));
        end
    end

    assign w_job = '{vec1: bus.in_vec1_i, vec2: bus.in_vec2_i,
                     scal: bus.in_scal_i, mode: bus.in_mode_i};

    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
        vpe_frame_bank u_bank (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .we_i         (w_we[gb]),
            .clear_mask_i (w_clear[gb]),
            .slot_i       (wslot_q),
            .job_i        (w_job),
            .vec1_o       (w_vec1[gb]),
            .vec2_o       (w_vec2[gb]),
            .scal_o       (w_scal[gb]),
            .mode_o       (w_mode[gb]),
            .mask_o       (w_mask[gb])
        );
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign w_gate          = w_out_valid ? w_mask[pres_ptr_q] : '0;

    always_comb begin
        bus.operand1_o  = '0;
        bus.operand2_o  = '0;
        bus.operand3_o  = '0;
        bus.mode_o      = '0;
        bus.slot_mask_o = w_gate;
        for (int i = 0; i < PARALLEL_SIZE; i++) begin
            for (int j = 0; j < PIPE_STAGE; j++) begin
                if (w_gate[i][j]) begin
                    bus.operand1_o[i][j] = w_vec1[pres_ptr_q][i][j];
                    bus.operand2_o[i][j] = w_vec2[pres_ptr_q][i][j];
                    bus.operand3_o[i][j] = w_scal[pres_ptr_q][i][j];
                    bus.mode_o[i][j]     = w_mode[pres_ptr_q][i][j];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vpe_frame_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vpe_frame_dispatcher
//  Brief    : Scoreboard bench for the ping-pong VPE frame dispatcher.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vpe_frame_dispatcher;
    import vpe_pkg::*;

    typedef struct {
        tile_vec_t            vec1;
        tile_vec_t            vec2;
        logic [MUL_WIDTH-1:0] scal;
        logic                 mode;
    } jb_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    vpe_frame_dispatcher_if bus ();
    vpe_frame_dispatcher dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    int  n_cmp = 0;
    int  n_bad = 0;
    jb_t job_q [$];     // jobs in presentation order, sealed frames first
    int  frame_q [$];   // job count of each sealed, not yet popped frame
    int  cur_cnt = 0;   // jobs in the frame being filled
    bit  m_ready = 1'b1;
    int  rdy_mode = 1;  // 0: hold off, 1: always take, 2: random
    jb_t cur_job;

    function automatic tile_vec_t mkvec(input logic [31:0] seed, input int which);
        tile_vec_t v;
        for (int e = 0; e < TILE_SIZE; e++)
            v[e] = 16'((seed >> (e % 16)) ^ (32'(e) * 32'h9E37 + 32'(which) * 32'h51ED));
        return v;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic frame_compare(input int cnt);
        int bad_k;
        logic [MUL_WIDTH-1:0] a3, e3;
        logic am, em, ak, ek, v1ok, v2ok;
        bad_k = -1;
        for (int k = 0; k < SLOTS; k++) begin
            int i, j;
            tile_vec_t x1, x2;
            logic [MUL_WIDTH-1:0] x3;
            logic xm, xk;
            i = k / PIPE_STAGE;
            j = k % PIPE_STAGE;
            if (k < cnt) begin
                x1 = job_q[k].vec1; x2 = job_q[k].vec2; x3 = job_q[k].scal; xm = job_q[k].mode; xk = 1'b1;
            end else begin
                x1 = '0; x2 = '0; x3 = '0; xm = 1'b0; xk = 1'b0;
            end
            if (bad_k < 0 && (bus.operand1_o[i][j] !== x1 || bus.operand2_o[i][j] !== x2 ||
                              bus.operand3_o[i][j] !== x3 || bus.mode_o[i][j] !== xm ||
                              bus.slot_mask_o[i][j] !== xk)) begin
                bad_k = k;
                a3 = bus.operand3_o[i][j]; e3 = x3;
                am = bus.mode_o[i][j];     em = xm;
                ak = bus.slot_mask_o[i][j]; ek = xk;
                v1ok = (bus.operand1_o[i][j] === x1);
                v2ok = (bus.operand2_o[i][j] === x2);
            end
        end
        n_cmp++;
        if (bad_k >= 0) begin
            n_bad++;
            $display("FAIL frame slot %0d (%0d,%0d): scal/mode/mask got %h/%b/%b expected %h/%b/%b vec1_match=%0b vec2_match=%0b at %0t",
                     bad_k, bad_k / PIPE_STAGE, bad_k % PIPE_STAGE, a3, am, ak, e3, em, ek, v1ok, v2ok, $time);
        end
    endtask

    // Monitor: compares presented state against the scoreboard, pops on handshake
    initial begin
        forever begin
            int cnt;
            @(negedge clk_i);
            cnt     = (frame_q.size() > 0) ? frame_q[0] : 0;
            m_ready = (frame_q.size() < 2);
            check("in_ready", 64'(bus.in_ready_o), 64'(m_ready));
            check("out_valid", 64'(bus.out_valid_o), 64'(frame_q.size() > 0));
            frame_compare(cnt);
            if (!rst_i && frame_q.size() > 0 && bus.out_ready_i) begin
                for (int k = 0; k < cnt; k++) void'(job_q.pop_front());
                void'(frame_q.pop_front());
            end
        end
    end

    // Reference model: one transaction per clock, evaluated before the edge
    function automatic void model_update();
        bit acc;
        if (rst_i) return;
        acc = bus.in_valid_i && m_ready;
        if (acc) begin
            job_q.push_back(cur_job);
            cur_cnt++;
        end
        if ((acc && cur_cnt == SLOTS) || (bus.flush_i && cur_cnt > 0)) begin
            frame_q.push_back(cur_cnt);
            cur_cnt = 0;
        end
    endfunction

    task automatic tick();
        bus.out_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        @(negedge clk_i);
        #1;
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_job(input logic [MUL_WIDTH-1:0] scal, input bit flush);
        bit done;
        cur_job.vec1 = mkvec($urandom, 0);
        cur_job.vec2 = mkvec($urandom, 1);
        cur_job.scal = scal;
        cur_job.mode = 1'($urandom_range(0, 1));
        bus.in_valid_i = 1'b1;
        bus.in_vec1_i  = cur_job.vec1;
        bus.in_vec2_i  = cur_job.vec2;
        bus.in_scal_i  = cur_job.scal;
        bus.in_mode_i  = cur_job.mode;
        bus.flush_i    = flush;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            bit hs;
            hs = bus.in_ready_o;
            tick();
            done = hs;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 300 cycles at %0t", $time);
        end
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic flush_only();
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b1;
        tick();
        bus.flush_i    = 1'b0;
    endtask

    property p_hold;
        @(posedge clk_i) disable iff (rst_i)
            (bus.in_valid_i && !bus.in_ready_o) |=>
            (bus.in_valid_i && $stable(bus.in_scal_i) && $stable(bus.in_mode_i) &&
             $stable(bus.in_vec1_i) && $stable(bus.in_vec2_i));
    endproperty
    a_hold: assert property (p_hold);

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_vec1_i   = '0;
        bus.in_vec2_i   = '0;
        bus.in_scal_i   = '0;
        bus.in_mode_i   = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Back-to-back full frame, consumer always ready
        rdy_mode = 1;
        for (int k = 0; k < SLOTS; k++) send_job(16'(k), 1'b0);
        idle(3);

        // Two frames with consumer stalled, then a single-cycle pop
        rdy_mode = 0;
        for (int k = 0; k < 2 * SLOTS; k++) send_job(16'(k), 1'b0);
        idle(3);
        rdy_mode = 1;
        tick();
        rdy_mode = 0;
        idle(3);
        rdy_mode = 1;
        idle(3);

        // Partial frame sealed by flush
        rdy_mode = 0;
        for (int k = 0; k < 5; k++) send_job(16'(100 + k), 1'b0);
        flush_only();
        idle(4);
        rdy_mode = 1;
        idle(2);

        // Flush on empty bank, then flush together with the 5th accept
        flush_only();
        idle(2);
        for (int k = 0; k < 4; k++) send_job(16'(200 + k), 1'b0);
        send_job(16'(204), 1'b1);
        idle(4);

        // Presented frame held while the other bank streams in
        rdy_mode = 0;
        for (int k = 0; k < SLOTS + 20; k++) send_job(16'(300 + k), 1'b0);
        idle(5);
        flush_only();
        rdy_mode = 1;
        idle(5);

        // Reset with a sealed frame pending and a partial frame filling
        rdy_mode = 0;
        for (int k = 0; k < SLOTS + 10; k++) send_job(16'(400 + k), 1'b0);
        rst_i = 1'b1;
        job_q.delete();
        frame_q.delete();
        cur_cnt = 0;
        idle(3);
        rst_i = 1'b0;
        rdy_mode = 1;
        send_job(16'hBEEF, 1'b1);
        idle(4);

        // Random traffic against the model
        rdy_mode = 2;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 7);
            if (r < 5)       send_job(16'($urandom), ($urandom_range(0, 15) == 0));
            else if (r == 5) flush_only();
            else             idle(1);
        end
        rdy_mode = 1;
        flush_only();
        idle(10);
        check("drained_frames", 64'(frame_q.size()), 64'd0);
        check("drained_jobs", 64'(job_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
